// File: rtl/telemetry_pkg.sv
// Shared constants and types for the telemetry frame scheduler.
// The checksum byte is compiled in only when TELEM_CHECKSUM_EN is defined.
package telemetry_pkg;
  localparam logic [7:0] HDR_BYTE       = 8'hA5;
  localparam int         FRAME_LEN      = 29;
  localparam int         FRAME_LEN_CSUM = 30;
  localparam int         IDX_W          = 5;
  localparam int         NUM_CH         = 8;
  localparam int         FREQ_W         = 24;
  // Index of the last snapshot byte (tem LSB); the checksum, if built, follows it.
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CSUM} state_t;
endpackage

// File: rtl/telem_byte_sel.sv
// Combinational byte mux: frame index -> byte from the captured snapshot.
// Index 0 and out-of-range indices yield the header byte.
module telem_byte_sel
  import telemetry_pkg::*;
(
  input  logic [IDX_W-1:0]              i_idx,
  input  logic [NUM_CH-1:0][FREQ_W-1:0] i_freq,
  input  logic [15:0]                   i_hum,
  input  logic [15:0]                   i_tem,
  output logic [7:0]                    o_byte
);
  always_comb begin
    o_byte = HDR_BYTE;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < 3; b++)
        if (i_idx == IDX_W'(1 + 3*c + b)) o_byte = i_freq[c][FREQ_W-1-8*b -: 8];
    case (i_idx)
      IDX_W'(25): o_byte = i_hum[15:8];
      IDX_W'(26): o_byte = i_hum[7:0];
      IDX_W'(27): o_byte = i_tem[15:8];
      IDX_W'(28): o_byte = i_tem[7:0];
      default: ;
    endcase
  end
endmodule

// File: rtl/telemetry_scheduler.sv
// Periodic / forced telemetry frame scheduler feeding a UART byte stream.
// Define TELEM_CHECKSUM_EN to append a mod-256 checksum byte (30-byte frame).
module telemetry_scheduler
  import telemetry_pkg::*;
#(
  parameter logic [31:0] PERIOD_CYCLES = 32'd50000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [23:0] freq_0_export,
  input  logic [23:0] freq_1_export,
  input  logic [23:0] freq_2_export,
  input  logic [23:0] freq_3_export,
  input  logic [23:0] freq_4_export,
  input  logic [23:0] freq_5_export,
  input  logic [23:0] freq_6_export,
  input  logic [23:0] freq_7_export,
  input  logic [15:0] hum_export,
  input  logic [15:0] tem_export,
  input  logic        force_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o,
  output logic [7:0]  overrun_cnt_o
);
  state_t                        r_state;
  logic [31:0]                   r_cnt;
  logic [IDX_W-1:0]              r_idx;
  logic [NUM_CH-1:0][FREQ_W-1:0] r_freq;
  logic [15:0]                   r_hum, r_tem;
  logic [7:0]                    r_data;
  logic                          r_valid;
  logic [15:0]                   r_frames;
  logic [7:0]                    r_ovr;
`ifdef TELEM_CHECKSUM_EN
  logic [7:0]                    r_csum;
`endif

  logic                          w_tick, w_trig, w_xfer, w_last;
  logic [IDX_W-1:0]              w_idx_nxt;
  logic [7:0]                    w_byte_nxt;
  logic [NUM_CH-1:0][FREQ_W-1:0] w_freq_in;

  assign w_freq_in = {freq_7_export, freq_6_export, freq_5_export, freq_4_export,
                      freq_3_export, freq_2_export, freq_1_export, freq_0_export};
  assign w_tick    = (r_cnt == PERIOD_CYCLES - 32'd1);
  assign w_trig    = w_tick | force_i;
  assign w_xfer    = r_valid & tx_ready_i;
  assign w_last    = (r_idx == LAST_DATA_IDX);
  assign w_idx_nxt = r_idx + IDX_W'(1);

  // Next byte is looked up ahead so tx_data_o stays a plain register.
  telem_byte_sel u_sel (
    .i_idx  (w_idx_nxt),
    .i_freq (r_freq),
    .i_hum  (r_hum),
    .i_tem  (r_tem),
    .o_byte (w_byte_nxt)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset)  r_cnt <= '0;
    else if (w_tick)  r_cnt <= '0;
    else              r_cnt <= r_cnt + 32'd1;
  end

  always_ff @(posedge clk_clk) begin
    if (r_state == ST_IDLE && w_trig) begin
      r_freq <= w_freq_in;
      r_hum  <= hum_export;
      r_tem  <= tem_export;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_frames <= '0;
      r_ovr    <= '0;
`ifdef TELEM_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      if (w_trig && r_state != ST_IDLE && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
      case (r_state)
        ST_IDLE: if (w_trig) begin
          r_state <= ST_SEND;
          r_idx   <= '0;
          r_data  <= HDR_BYTE;
          r_valid <= 1'b1;
`ifdef TELEM_CHECKSUM_EN
          r_csum  <= '0;
`endif
        end
        ST_SEND: if (w_xfer) begin
`ifdef TELEM_CHECKSUM_EN
          if (r_idx != '0) r_csum <= r_csum + r_data;
`endif
          if (w_last) begin
`ifdef TELEM_CHECKSUM_EN
            r_state <= ST_CSUM;
            r_data  <= r_csum + r_data;
`else
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_frames <= r_frames + 16'd1;
`endif
          end else begin
            r_idx  <= w_idx_nxt;
            r_data <= w_byte_nxt;
          end
        end
`ifdef TELEM_CHECKSUM_EN
        ST_CSUM: if (w_xfer) begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
          r_frames <= r_frames + 16'd1;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data_o     = r_data;
  assign tx_valid_o    = r_valid;
  assign busy_o        = (r_state != ST_IDLE);
  assign frame_cnt_o   = r_frames;
  assign overrun_cnt_o = r_ovr;
endmodule

// File: tb/tb_telemetry_scheduler.sv
// Directed bench for telemetry_scheduler with a byte scoreboard.
// Honours TELEM_CHECKSUM_EN for frame length and the trailing checksum byte.
module tb_telemetry_scheduler;
  localparam int FLEN =
`ifdef TELEM_CHECKSUM_EN
    30;
`else
    29;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [23:0] fr [8];
  logic [15:0] hum_export = '0, tem_export = '0;
  logic        force_i = 1'b0, tx_ready_i = 1'b0;
  logic [7:0]  tx_data_o, overrun_cnt_o;
  logic        tx_valid_o, busy_o;
  logic [15:0] frame_cnt_o;

  int          tests = 0, fails = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  held, e;
  bit          stall_q = 1'b0;

  always #5 clk_clk = ~clk_clk;

  telemetry_scheduler #(.PERIOD_CYCLES(32'd100)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .freq_0_export(fr[0]), .freq_1_export(fr[1]), .freq_2_export(fr[2]), .freq_3_export(fr[3]),
    .freq_4_export(fr[4]), .freq_5_export(fr[5]), .freq_6_export(fr[6]), .freq_7_export(fr[7]),
    .hum_export(hum_export), .tem_export(tem_export), .force_i(force_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o), .overrun_cnt_o(overrun_cnt_o)
  );

  // Byte monitor: inputs move 1 time unit after posedge, so negedge sees settled values.
  always @(negedge clk_clk) begin
    if (reset_reset) stall_q = 1'b0;
    else begin
      if (stall_q && tx_valid_o) begin
        tests++;
        assert (tx_data_o === held) else begin
          fails++; $error("FAIL stall_hold got %h exp %h", tx_data_o, held);
        end
      end
      if (tx_valid_o && tx_ready_i) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++; $error("FAIL extra_byte got %h exp none", tx_data_o);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          assert (tx_data_o === e) else begin
            fails++; $error("FAIL frame_byte got %h exp %h", tx_data_o, e);
          end
        end
      end
      stall_q = tx_valid_o && !tx_ready_i;
      held    = tx_data_o;
    end
  end

  task automatic tk();
    @(posedge clk_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    exp_q.delete();
    tk();
    reset_reset = 1'b0;
  endtask

  task automatic push_frame();
    logic [7:0] b, s;
    s = 8'h00;
    exp_q.push_back(8'hA5);
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 3; k++) begin
        b = fr[c][23-8*k -: 8]; exp_q.push_back(b); s = s + b;
      end
    b = hum_export[15:8]; exp_q.push_back(b); s = s + b;
    b = hum_export[7:0];  exp_q.push_back(b); s = s + b;
    b = tem_export[15:8]; exp_q.push_back(b); s = s + b;
    b = tem_export[7:0];  exp_q.push_back(b); s = s + b;
`ifdef TELEM_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic scramble_inputs();
    for (int c = 0; c < 8; c++) fr[c] = 24'($urandom);
    hum_export = 16'($urandom);
    tem_export = 16'($urandom);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (tx_valid_o && n < 400) begin tk(); n++; end
  endtask

  initial begin
    int n;
    for (int c = 0; c < 8; c++) fr[c] = '0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_data",  32'(tx_data_o), 32'h00);
    chk("rst_frame", 32'(frame_cnt_o), 32'd0);
    chk("rst_ovr",   32'(overrun_cnt_o), 32'd0);

    // Periodic tick frame, ready held high
    fr[0] = 24'h123456; tx_ready_i = 1'b1;
    push_frame();
    repeat (99) tk();
    chk("tick_pre_valid", 32'(tx_valid_o), 32'd0);
    tk();
    scramble_inputs();
    chk("tick_valid", 32'(tx_valid_o), 32'd1);
    chk("tick_hdr",   32'(tx_data_o), 32'hA5);
    drain(n);
    chk("tick_len",   32'(n), 32'(FLEN));
    chk("tick_frame", 32'(frame_cnt_o), 32'd1);
    chk("tick_q",     32'(exp_q.size()), 32'd0);

    // Stalled frame: ready high one cycle in three; inputs change mid-frame
    do_reset();
    tx_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) fr[c] = 24'h102030 + 24'(c) * 24'h010101;
    hum_export = 16'hBEEF; tem_export = 16'h1234;
    push_frame();
    force_i = 1'b1; tk(); force_i = 1'b0;
    scramble_inputs();
    n = 0;
    while (tx_valid_o && n < 400) begin
      tx_ready_i = (n % 3 == 2); tk(); n++;
    end
    chk("stall_cycles", 32'(n), 32'(3 * FLEN));
    chk("stall_frame",  32'(frame_cnt_o), 32'd1);
    chk("stall_q",      32'(exp_q.size()), 32'd0);

    // Overrun: forces while busy are dropped and counted, saturating
    tx_ready_i = 1'b0;
    do_reset();
    push_frame();
    force_i = 1'b1; tk(); force_i = 1'b0;
    tk();
    force_i = 1'b1; tk(); force_i = 1'b0;
    chk("ovr_one",  32'(overrun_cnt_o), 32'd1);
    chk("ovr_busy", 32'(busy_o), 32'd1);
    force_i = 1'b1; repeat (300) tk(); force_i = 1'b0;
    chk("ovr_sat",  32'(overrun_cnt_o), 32'd255);
    tx_ready_i = 1'b1;
    drain(n);
    chk("ovr_len",   32'(n), 32'(FLEN));
    chk("ovr_frame", 32'(frame_cnt_o), 32'd1);
    repeat (5) tk();
    chk("ovr_idle",  32'(tx_valid_o), 32'd0);
    chk("ovr_q",     32'(exp_q.size()), 32'd0);

    // Reset at byte 10 abandons the frame; next frame restarts at the header
    do_reset();
    scramble_inputs();
    push_frame();
    force_i = 1'b1; tk(); force_i = 1'b0;
    tk();
    force_i = 1'b1; tk(); force_i = 1'b0;
    repeat (8) tk();
    chk("mid_ovr", 32'(overrun_cnt_o), 32'd1);
    reset_reset = 1'b1; exp_q.delete(); tk(); reset_reset = 1'b0;
    chk("mid_valid", 32'(tx_valid_o), 32'd0);
    chk("mid_busy",  32'(busy_o), 32'd0);
    chk("mid_data",  32'(tx_data_o), 32'h00);
    chk("mid_ovr0",  32'(overrun_cnt_o), 32'd0);
    chk("mid_frame0",32'(frame_cnt_o), 32'd0);
    scramble_inputs();
    push_frame();
    force_i = 1'b1; tk(); force_i = 1'b0;
    chk("mid_hdr", 32'(tx_data_o), 32'hA5);
    drain(n);
    chk("mid_len",   32'(n), 32'(FLEN));
    chk("mid_frame", 32'(frame_cnt_o), 32'd1);

    // Tick and force in the same cycle start one frame, no overrun
    do_reset();
    for (int c = 0; c < 8; c++) fr[c] = '0;
    hum_export = 16'hFFFF; tem_export = 16'h0102;
    repeat (99) tk();
    push_frame();
    force_i = 1'b1; tk(); force_i = 1'b0;
    chk("both_valid", 32'(tx_valid_o), 32'd1);
    chk("both_ovr",   32'(overrun_cnt_o), 32'd0);
    drain(n);
    chk("both_len",   32'(n), 32'(FLEN));
    repeat (5) tk();
    chk("both_frame", 32'(frame_cnt_o), 32'd1);
    chk("both_ovr2",  32'(overrun_cnt_o), 32'd0);
    chk("both_busy",  32'(busy_o), 32'd0);
    chk("both_q",     32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
